// File: rtl/eth_mdio_pkg.sv
// rtl/eth_mdio_pkg.sv - shared constants and FSM state type for the MDIO responder
package eth_mdio_pkg;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ST,
    ST_OP,
    ST_PHYAD,
    ST_REGAD,
    ST_TA,
    ST_WDATA,
    ST_RDATA,
    ST_SKIP
  } mdio_state_t;

endpackage

// File: rtl/eth_mdio_responder_if.sv
// rtl/eth_mdio_responder_if.sv - register-file bus between the responder and its 32x16 register file
interface eth_mdio_responder_if;
  import eth_mdio_pkg::*;

  logic [REGAD_W-1:0] RegAddr;
  logic               RegRdEn;
  logic [DATA_W-1:0]  RegRdData;
  logic               RegWrEn;
  logic [DATA_W-1:0]  RegWrData;

  modport master (
    output RegAddr, RegRdEn, RegWrEn, RegWrData,
    input  RegRdData
  );

  modport slave (
    input  RegAddr, RegRdEn, RegWrEn, RegWrData,
    output RegRdData
  );

endinterface

// File: rtl/eth_mdio_sync_edge.sv
// rtl/eth_mdio_sync_edge.sv - 2-flop synchronizers for Mdc/Mdi and the Mdc rising-edge sample strobe
module eth_mdio_sync_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic Mdc,
  input  logic Mdi,
  output logic mdc_rise,
  output logic mdi_sync
);

  logic [1:0] mdc_ff;
  logic [1:0] mdi_ff;
  logic       mdc_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mdc_ff <= '0;
      mdi_ff <= '0;
      mdc_d  <= 1'b0;
    end else begin
      mdc_ff <= {mdc_ff[0], Mdc};
      mdi_ff <= {mdi_ff[0], Mdi};
      mdc_d  <= mdc_ff[1];
    end
  end

  // Mdi takes the same two-flop path, so it lines up with the strobe.
  assign mdc_rise = mdc_ff[1] & ~mdc_d;
  assign mdi_sync = mdi_ff[1];

endmodule

// File: rtl/eth_mdio_responder.sv
// rtl/eth_mdio_responder.sv - clause-22 MDIO responder: decodes frames on the oversampled Mdc edge
// and issues single-cycle read/write strobes to a local register file.
module eth_mdio_responder
  import eth_mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'h01,
  parameter bit                 BCAST_EN = 1'b1,
  parameter int                 PRE_LEN  = 32,
  parameter bit                 NOPRE_OK = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Mdc,
  input  logic                  Mdi,
  output logic                  Mdo,
  output logic                  MdoEn,
  eth_mdio_responder_if.master  reg_bus,
  output logic                  Busy,
  output logic                  FrameErr
);

  // Preamble count must be able to hold PRE_LEN itself.
  localparam int                PRE_W   = $clog2(PRE_LEN + 1);
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRE_LEN);

  mdio_state_t         state;
  logic [PRE_W-1:0]    pre_cnt;
  logic [4:0]          bit_cnt;
  logic [1:0]          op;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   rd_sh;
  logic                rd_cap;
  logic                match;
  logic                last_ok;
  logic                s;
  logic                mdi;

  eth_mdio_sync_edge u_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .Mdc      (Mdc),
    .Mdi      (Mdi),
    .mdc_rise (s),
    .mdi_sync (mdi)
  );

  assign Busy = (state != ST_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state             <= ST_IDLE;
      pre_cnt           <= '0;
      bit_cnt           <= '0;
      op                <= '0;
      shreg             <= '0;
      rd_sh             <= '0;
      rd_cap            <= 1'b0;
      match             <= 1'b0;
      last_ok           <= 1'b0;
      Mdo               <= 1'b0;
      MdoEn             <= 1'b0;
      FrameErr          <= 1'b0;
      reg_bus.RegAddr   <= '0;
      reg_bus.RegRdEn   <= 1'b0;
      reg_bus.RegWrEn   <= 1'b0;
      reg_bus.RegWrData <= '0;
    end else begin
      reg_bus.RegRdEn <= 1'b0;
      reg_bus.RegWrEn <= 1'b0;
      FrameErr        <= 1'b0;
      rd_cap          <= reg_bus.RegRdEn;
      if (rd_cap) rd_sh <= reg_bus.RegRdData;

      if (s) begin
        case (state)
          ST_IDLE: begin
            if (mdi) begin
              if (pre_cnt < PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
            end else begin
              pre_cnt <= '0;
              if (pre_cnt >= PRE_MAX || (NOPRE_OK && last_ok)) begin
                state   <= ST_ST;
                last_ok <= 1'b0;
              end
            end
          end
          ST_ST: begin
            bit_cnt <= '0;
            if (mdi) state <= ST_OP;
            else begin
              FrameErr <= 1'b1;
              state    <= ST_IDLE;
            end
          end
          ST_OP: begin
            op <= {op[0], mdi};
            if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              if ({op[0], mdi} == OP_READ || {op[0], mdi} == OP_WRITE) state <= ST_PHYAD;
              else begin
                FrameErr <= 1'b1;
                state    <= ST_IDLE;
              end
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          ST_PHYAD: begin
            shreg <= {shreg[DATA_W-2:0], mdi};
            if (bit_cnt == 5'd4) begin
              match   <= ({shreg[3:0], mdi} == PHY_ADDR) ||
                         (BCAST_EN && {shreg[3:0], mdi} == '0 && op == OP_WRITE);
              bit_cnt <= '0;
              state   <= ST_REGAD;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          ST_REGAD: begin
            shreg <= {shreg[DATA_W-2:0], mdi};
            if (bit_cnt == 5'd4) begin
              reg_bus.RegAddr <= {shreg[3:0], mdi};
              bit_cnt         <= '0;
              if (match) begin
                reg_bus.RegRdEn <= (op == OP_READ);
                state           <= ST_TA;
              end else state <= ST_SKIP;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          ST_TA: begin
            if (op == OP_READ) begin
              // Master has released the pad during TA bit 1; drive the TA 0 from here.
              MdoEn   <= 1'b1;
              Mdo     <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_RDATA;
            end else begin
              shreg <= {shreg[DATA_W-2:0], mdi};
              if (bit_cnt == 5'd1) begin
                bit_cnt <= '0;
                if ({shreg[0], mdi} == 2'b10) state <= ST_WDATA;
                else begin
                  FrameErr <= 1'b1;
                  state    <= ST_IDLE;
                end
              end else bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_WDATA: begin
            shreg <= {shreg[DATA_W-2:0], mdi};
            if (bit_cnt == 5'(DATA_W - 1)) begin
              reg_bus.RegWrData <= {shreg[DATA_W-2:0], mdi};
              reg_bus.RegWrEn   <= 1'b1;
              last_ok           <= 1'b1;
              state             <= ST_IDLE;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          ST_RDATA: begin
            if (bit_cnt == 5'(DATA_W)) begin
              MdoEn   <= 1'b0;
              Mdo     <= 1'b0;
              last_ok <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              Mdo     <= rd_sh[DATA_W-1];
              rd_sh   <= {rd_sh[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_SKIP: begin
            // TA (2) plus data (16) belong to another PHY.
            if (bit_cnt == 5'd17) begin
              last_ok <= 1'b1;
              state   <= ST_IDLE;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_mdio_responder.sv
// tb/tb_eth_mdio_responder.sv - directed bench for eth_mdio_responder with a small register-file model
module tb_eth_mdio_responder;

  logic Clk;
  logic Reset;
  logic Mdc;
  logic Mdi;
  logic Mdo;
  logic MdoEn;
  logic Busy;
  logic FrameErr;

  eth_mdio_responder_if bus ();

  eth_mdio_responder dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Mdc      (Mdc),
    .Mdi      (Mdi),
    .Mdo      (Mdo),
    .MdoEn    (MdoEn),
    .reg_bus  (bus.master),
    .Busy     (Busy),
    .FrameErr (FrameErr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  logic [15:0] mem [32];

  always @(posedge Clk) begin
    if (Reset) begin
      mem[2]        <= 16'hA5C3;
      bus.RegRdData <= 16'h0000;
    end else begin
      if (bus.RegRdEn) bus.RegRdData <= mem[bus.RegAddr];
      if (bus.RegWrEn) mem[bus.RegAddr] <= bus.RegWrData;
    end
  end

  int rd_pulses = 0;
  int wr_pulses = 0;
  int err_pulses = 0;
  int en_cycles = 0;
  int collide = 0;

  always @(negedge Clk) begin
    if (bus.RegRdEn) rd_pulses++;
    if (bus.RegWrEn) wr_pulses++;
    if (FrameErr) err_pulses++;
    if (MdoEn) en_cycles++;
    if (bus.RegRdEn && bus.RegWrEn) collide++;
    if (FrameErr && (bus.RegRdEn || bus.RegWrEn)) collide++;
  end

  int errors = 0;
  int checks = 0;
  int rd0, wr0, err0, en0;
  logic [63:0] mdo_log, en_log, busy_log;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    rd0 = rd_pulses; wr0 = wr_pulses; err0 = err_pulses; en0 = en_cycles;
  endtask

  // Master-side bit: Mdi changes with Mdc low, Mdo/MdoEn/Busy sampled just before the rising edge.
  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      Mdc = 1'b0;
      Mdi = v[i];
      #40;
      mdo_log  = {mdo_log[62:0], Mdo};
      en_log   = {en_log[62:0], MdoEn};
      busy_log = {busy_log[62:0], Busy};
      Mdc = 1'b1;
      #40;
    end
  endtask

  task automatic frame(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d);
    send_bits({32'd0, st, op, phy, ra, ta, d}, 32);
  endtask

  initial begin
    Reset = 1'b1; Mdc = 1'b0; Mdi = 1'b1;
    mdo_log = '0; en_log = '0; busy_log = '0;
    #2;
    #40;
    check("rst_mdoen", MdoEn, 0);
    check("rst_mdo", Mdo, 0);
    check("rst_regaddr", bus.RegAddr, 0);
    check("rst_strobes", {bus.RegRdEn, bus.RegWrEn, FrameErr}, 0);
    check("rst_wrdata", bus.RegWrData, 0);
    check("rst_busy", Busy, 0);
    Reset = 1'b0;
    #40;

    // Read PHY 01 reg 02
    snap();
    send_bits('1, 32);
    frame(2'b01, 2'b10, 5'h01, 5'h02, 2'b11, 16'hFFFF);
    #200;
    check("rd_pulse", rd_pulses - rd0, 1);
    check("rd_nowr", wr_pulses - wr0, 0);
    check("rd_addr", bus.RegAddr, 5'h02);
    check("rd_ta1_en", en_log[17], 0);
    check("rd_ta2_en_mdo", {en_log[16], mdo_log[16]}, 2'b10);
    check("rd_data", mdo_log[15:0], 16'hA5C3);
    check("rd_data_en", en_log[15:0], 16'hFFFF);
    check("rd_end_en", MdoEn, 0);
    check("rd_end_busy", Busy, 0);

    // Write PHY 01 reg 1F
    snap();
    send_bits('1, 32);
    frame(2'b01, 2'b01, 5'h01, 5'h1F, 2'b10, 16'h1234);
    #200;
    check("wr_pulse", wr_pulses - wr0, 1);
    check("wr_nord", rd_pulses - rd0, 0);
    check("wr_addr", bus.RegAddr, 5'h1F);
    check("wr_data", bus.RegWrData, 16'h1234);
    check("wr_no_en", en_cycles - en0, 0);
    check("wr_no_err", err_pulses - err0, 0);

    // Read to foreign PHY 05, then a normal read of reg 1F
    snap();
    send_bits('1, 32);
    frame(2'b01, 2'b10, 5'h05, 5'h1F, 2'b11, 16'hFFFF);
    #200;
    check("skip_nord", rd_pulses - rd0, 0);
    check("skip_no_en", en_cycles - en0, 0);
    check("skip_busy", busy_log[30:0], 31'h7FFF_FFFF);
    check("skip_idle", Busy, 0);
    snap();
    send_bits('1, 32);
    frame(2'b01, 2'b10, 5'h01, 5'h1F, 2'b11, 16'hFFFF);
    #200;
    check("after_skip_rd", rd_pulses - rd0, 1);
    check("after_skip_data", mdo_log[15:0], 16'h1234);

    // Write with bad turnaround
    snap();
    send_bits('1, 32);
    frame(2'b01, 2'b01, 5'h01, 5'h03, 2'b11, 16'h5670);
    #200;
    check("ta11_err", err_pulses - err0, 1);
    check("ta11_nowr", wr_pulses - wr0, 0);

    // Short preamble after an errored frame: ignored entirely
    snap();
    send_bits('1, 31);
    frame(2'b01, 2'b01, 5'h01, 5'h04, 2'b10, 16'h00F0);
    #200;
    check("pre31_strobes", (wr_pulses - wr0) + (rd_pulses - rd0), 0);
    check("pre31_err", err_pulses - err0, 0);
    check("pre31_busy", busy_log[31:0], 32'h0);

    // Illegal opcode 11
    snap();
    send_bits('1, 32);
    send_bits(64'h7, 4);
    #200;
    check("op11_err", err_pulses - err0, 1);
    check("op11_idle", Busy, 0);

    // Back-to-back write then read without preamble
    snap();
    send_bits('1, 32);
    frame(2'b01, 2'b01, 5'h01, 5'h05, 2'b10, 16'hBEEF);
    frame(2'b01, 2'b10, 5'h01, 5'h05, 2'b11, 16'hFFFF);
    #200;
    check("b2b_wr", wr_pulses - wr0, 1);
    check("b2b_rd", rd_pulses - rd0, 1);
    check("b2b_data", mdo_log[15:0], 16'hBEEF);
    check("b2b_err", err_pulses - err0, 0);

    // Reset in the middle of read data
    send_bits({40'd0, 2'b01, 2'b10, 5'h01, 5'h05, 2'b11, 8'hFF}, 24);
    check("mid_rdata_en", en_log[0], 1);
    #4;
    Reset = 1'b1;
    #1;
    check("rst_async_en", MdoEn, 0);
    check("rst_async_busy", Busy, 0);
    #25;
    Reset = 1'b0;
    #20;
    check("no_collide", collide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
